// File: rtl/axi4lite_cmd_initiator.sv
// Single-outstanding AXI4-Lite manager: turns one valid/ready command into one AXI4-Lite read or write.
// Optional build macro AXIL_ERRCNT_EN adds err_count, a saturating tally of non-OKAY responses.
`timescale 1ns/1ps
module axi4lite_cmd_initiator #(
    parameter logic [2:0] PROT  = 3'b000,
    parameter logic [3:0] CACHE = 4'b0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic [3:0]  awcache,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic [3:0]  arcache,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp
`ifdef AXIL_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        aw_done_r;
    logic        w_done_r;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        aw_ok_s;
    logic        w_ok_s;

    logic        awvalid_nxt_s;
    logic        wvalid_nxt_s;
    logic        bready_nxt_s;
    logic        arvalid_nxt_s;
    logic        rready_nxt_s;
    logic        rsp_valid_nxt_s;
    logic        rsp_write_nxt_s;
    logic [31:0] rsp_rdata_nxt_s;
    logic [1:0]  rsp_resp_nxt_s;
    logic [31:0] awaddr_nxt_s;
    logic [31:0] wdata_nxt_s;
    logic [3:0]  wstrb_nxt_s;
    logic [31:0] araddr_nxt_s;
    logic        aw_done_nxt_s;
    logic        w_done_nxt_s;

    assign cmd_ready = (state_r == ST_IDLE);
    assign awprot    = PROT;
    assign arprot    = PROT;
    assign awcache   = CACHE;
    assign arcache   = CACHE;

    // AW and W complete independently; a handshake this cycle counts as done.
    assign aw_hs_s = awvalid & awready;
    assign w_hs_s  = wvalid & wready;
    assign aw_ok_s = aw_done_r | aw_hs_s;
    assign w_ok_s  = w_done_r | w_hs_s;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = cmd_write ? ST_WADDR : ST_RADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WADDR: begin
                if (aw_ok_s && w_ok_s) begin
                    state_nxt_s = ST_WRESP;
                end else begin
                    state_nxt_s = ST_WADDR;
                end
            end
            ST_WRESP: begin
                if (bvalid && bready) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WRESP;
                end
            end
            ST_RADDR: begin
                if (arvalid && arready) begin
                    state_nxt_s = ST_RDATA;
                end else begin
                    state_nxt_s = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (rvalid && rready) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_RDATA;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        awvalid_nxt_s   = awvalid;
        wvalid_nxt_s    = wvalid;
        bready_nxt_s    = bready;
        arvalid_nxt_s   = arvalid;
        rready_nxt_s    = rready;
        rsp_valid_nxt_s = rsp_valid;
        rsp_write_nxt_s = rsp_write;
        rsp_rdata_nxt_s = rsp_rdata;
        rsp_resp_nxt_s  = rsp_resp;
        awaddr_nxt_s    = awaddr;
        wdata_nxt_s     = wdata;
        wstrb_nxt_s     = wstrb;
        araddr_nxt_s    = araddr;
        aw_done_nxt_s   = aw_done_r;
        w_done_nxt_s    = w_done_r;
        case (state_r)
            ST_IDLE: begin
                aw_done_nxt_s = 1'b0;
                w_done_nxt_s  = 1'b0;
                if (cmd_valid && cmd_write) begin
                    awaddr_nxt_s  = cmd_addr;
                    wdata_nxt_s   = cmd_wdata;
                    wstrb_nxt_s   = cmd_wstrb;
                    awvalid_nxt_s = 1'b1;
                    wvalid_nxt_s  = 1'b1;
                end else if (cmd_valid) begin
                    araddr_nxt_s  = cmd_addr;
                    arvalid_nxt_s = 1'b1;
                end else begin
                    awvalid_nxt_s = 1'b0;
                    arvalid_nxt_s = 1'b0;
                end
            end
            ST_WADDR: begin
                if (aw_hs_s) begin
                    awvalid_nxt_s = 1'b0;
                    aw_done_nxt_s = 1'b1;
                end else begin
                    aw_done_nxt_s = aw_done_r;
                end
                if (w_hs_s) begin
                    wvalid_nxt_s = 1'b0;
                    w_done_nxt_s = 1'b1;
                end else begin
                    w_done_nxt_s = w_done_r;
                end
                if (aw_ok_s && w_ok_s) begin
                    bready_nxt_s  = 1'b1;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    bready_nxt_s = 1'b0;
                end
            end
            ST_WRESP: begin
                if (bvalid && bready) begin
                    bready_nxt_s    = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_write_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = 32'h0000_0000;
                    rsp_resp_nxt_s  = bresp;
                end else begin
                    bready_nxt_s = 1'b1;
                end
            end
            ST_RADDR: begin
                if (arvalid && arready) begin
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                end else begin
                    arvalid_nxt_s = 1'b1;
                end
            end
            ST_RDATA: begin
                if (rvalid && rready) begin
                    rready_nxt_s    = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_write_nxt_s = 1'b0;
                    rsp_rdata_nxt_s = rdata;
                    rsp_resp_nxt_s  = rresp;
                end else begin
                    rready_nxt_s = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                end else begin
                    rsp_valid_nxt_s = rsp_valid;
                end
            end
            default: begin
                awvalid_nxt_s   = 1'b0;
                wvalid_nxt_s    = 1'b0;
                bready_nxt_s    = 1'b0;
                arvalid_nxt_s   = 1'b0;
                rready_nxt_s    = 1'b0;
                rsp_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and progress-flag registers; reset abandons any transaction in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_resp  <= 2'b00;
            awaddr    <= 32'h0000_0000;
            wdata     <= 32'h0000_0000;
            wstrb     <= 4'h0;
            araddr    <= 32'h0000_0000;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            awvalid   <= awvalid_nxt_s;
            wvalid    <= wvalid_nxt_s;
            bready    <= bready_nxt_s;
            arvalid   <= arvalid_nxt_s;
            rready    <= rready_nxt_s;
            rsp_valid <= rsp_valid_nxt_s;
            rsp_write <= rsp_write_nxt_s;
            rsp_rdata <= rsp_rdata_nxt_s;
            rsp_resp  <= rsp_resp_nxt_s;
            awaddr    <= awaddr_nxt_s;
            wdata     <= wdata_nxt_s;
            wstrb     <= wstrb_nxt_s;
            araddr    <= araddr_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
        end
    end

`ifdef AXIL_ERRCNT_EN
    logic [15:0] err_cnt_r;
    logic        err_hit_s;

    assign err_hit_s = ((state_r == ST_WRESP) && bvalid && bready && (bresp != 2'b00)) ||
                       ((state_r == ST_RDATA) && rvalid && rready && (rresp != 2'b00));

    // Saturating count of non-OKAY B/R responses
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt_r <= 16'd0;
        end else if (err_hit_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_count = err_cnt_r;
`endif

endmodule

// File: tb/tb_axi4lite_cmd_initiator.sv
// Directed bench for axi4lite_cmd_initiator: table of transactions against a delay-configurable responder,
// plus hand sequences for response back-pressure, stray B/R valids and reset mid-write.
`timescale 1ns/1ps
module tb_axi4lite_cmd_initiator;

    logic        aclk, aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  awcache, arcache, wstrb;
    logic [1:0]  bresp, rresp;
`ifdef AXIL_ERRCNT_EN
    logic [15:0] err_count;
`endif

    axi4lite_cmd_initiator dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot), .awcache(awcache),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot), .arcache(arcache),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
`ifdef AXIL_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        int          a_dly;
        int          w_dly;
        int          x_dly;
        logic [1:0]  resp;
        logic [31:0] rdat;
        int          exp_a;
        int          exp_d;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [15:0] exp_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rsp_hs_cnt = 0;
    int cmd_cyc;

    // responder configuration and observations
    int          cfg_aw_dly, cfg_w_dly, cfg_x_dly;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;
    logic        spurious;
    int          viol;
    int          a_hs_abs, d_hs_abs;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (aresetn && rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
    end

    // Subordinate model: acts on negedges, readys/valids appear after configured delays
    initial begin : responder
        logic awv_l, wv_l, arv_l, bready_l, rready_l;
        logic [31:0] awaddr_l, wdata_l, araddr_l;
        logic [3:0] wstrb_l;
        logic aw_done, w_done, ar_done;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        viol = 0; a_hs_abs = 0; d_hs_abs = 0;
        cap_awaddr = 32'h0; cap_wdata = 32'h0; cap_araddr = 32'h0; cap_wstrb = 4'h0;
        awv_l = 1'b0; wv_l = 1'b0; arv_l = 1'b0; bready_l = 1'b0; rready_l = 1'b0;
        awaddr_l = 32'h0; wdata_l = 32'h0; araddr_l = 32'h0; wstrb_l = 4'h0;
        aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
                aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                awv_l = 1'b0; wv_l = 1'b0; arv_l = 1'b0; bready_l = 1'b0; rready_l = 1'b0;
            end else if (spurious) begin
                bvalid = 1'b1; rvalid = 1'b1;
            end else begin
                if (awv_l && awready) begin aw_done = 1'b1; a_hs_abs = cyc - 1; cap_awaddr = awaddr_l; end
                if (wv_l && wready) begin
                    w_done = 1'b1; d_hs_abs = cyc - 1; cap_wdata = wdata_l; cap_wstrb = wstrb_l;
                end
                if (arv_l && arready) begin ar_done = 1'b1; a_hs_abs = cyc - 1; cap_araddr = araddr_l; end
                if (bvalid && bready_l) begin
                    bvalid = 1'b0; aw_done = 1'b0; w_done = 1'b0;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end
                if (rvalid && rready_l) begin
                    rvalid = 1'b0; ar_done = 1'b0; d_hs_abs = cyc - 1;
                    ar_cnt = 0; r_cnt = 0;
                end
                if (awv_l && !awready && (!awvalid || awaddr != awaddr_l)) viol++;
                if (wv_l && !wready && (!wvalid || wdata != wdata_l || wstrb != wstrb_l)) viol++;
                if (arv_l && !arready && (!arvalid || araddr != araddr_l)) viol++;
                if ((aw_done && awvalid) || (w_done && wvalid)) viol++;
                if (bready && !(aw_done && w_done)) viol++;
                if ((ar_done && !rready) || (rready && !ar_done)) viol++;
                awready = awvalid && !aw_done && (aw_cnt >= cfg_aw_dly);
                if (awvalid && !aw_done && !awready) aw_cnt++;
                wready = wvalid && !w_done && (w_cnt >= cfg_w_dly);
                if (wvalid && !w_done && !wready) w_cnt++;
                arready = arvalid && !ar_done && (ar_cnt >= cfg_aw_dly);
                if (arvalid && !ar_done && !arready) ar_cnt++;
                if (!(aw_done && w_done)) bvalid = 1'b0;
                if (!ar_done) rvalid = 1'b0;
                if (aw_done && w_done && !bvalid) begin
                    if (b_cnt >= cfg_x_dly) begin bvalid = 1'b1; bresp = cfg_resp; end
                    else b_cnt++;
                end
                if (ar_done && !rvalid) begin
                    if (r_cnt >= cfg_x_dly) begin rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_resp; end
                    else r_cnt++;
                end
            end
            awv_l = awvalid; wv_l = wvalid; arv_l = arvalid; bready_l = bready; rready_l = rready;
            awaddr_l = awaddr; wdata_l = wdata; wstrb_l = wstrb; araddr_l = araddr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] dat,
                             input logic [3:0] strb);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = dat; cmd_wstrb = strb; cmd_valid = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_cyc = cyc;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge aclk);
            n++;
        end
        lat = cyc - cmd_cyc;
        check("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic consume(input int hs_before);
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_consume", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_consume", 32'(cmd_ready), 32'd1);
        check("one_response", 32'(rsp_hs_cnt), 32'(hs_before + 1));
    endtask

    task automatic run_vec(input vec_t v);
        int lat, viol0, hs0;
        cfg_aw_dly = v.a_dly; cfg_w_dly = v.w_dly; cfg_x_dly = v.x_dly;
        cfg_resp = v.resp; cfg_rdata = v.rdat;
        viol0 = viol; hs0 = rsp_hs_cnt;
        start_cmd(v.wr, v.addr, v.wdat, v.strb);
        wait_rsp(lat);
        check("latency", 32'(lat), 32'(v.exp_lat));
        check("rsp_write", 32'(rsp_write), 32'(v.wr));
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_resp", 32'(rsp_resp), 32'(v.resp));
        check("addr_hs_cycle", 32'(a_hs_abs - cmd_cyc), 32'(v.exp_a));
        check("data_hs_cycle", 32'(d_hs_abs - cmd_cyc), 32'(v.exp_d));
        if (v.wr) begin
            check("awaddr", cap_awaddr, v.addr);
            check("wdata", cap_wdata, v.wdat);
            check("wstrb", 32'(cap_wstrb), 32'(v.strb));
        end else begin
            check("araddr", cap_araddr, v.addr);
        end
`ifdef AXIL_ERRCNT_EN
        check("err_count", 32'(err_count), 32'(v.exp_err));
`endif
        consume(hs0);
        check("protocol", 32'(viol), 32'(viol0));
    endtask

    vec_t vec [7];
    vec_t post;

    initial begin : main
        int lat, hs0, bad;
        vec[0] = '{1'b1, 32'h0000_6000, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1, 1, 3, 32'h0, 16'd0};
        vec[1] = '{1'b1, 32'h0000_6004, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 2'b00, 32'h0, 4, 1, 6, 32'h0, 16'd0};
        vec[2] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 5, 2'b00, 32'hDEAD_BEEF, 1, 7, 8, 32'hDEAD_BEEF, 16'd0};
        vec[3] = '{1'b1, 32'h0000_7000, 32'h0000_55AA, 4'h5, 0, 2, 0, 2'b10, 32'hFFFF_FFFF, 1, 3, 5, 32'h0, 16'd1};
        vec[4] = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 2, 0, 0, 2'b10, 32'h1234_5678, 3, 4, 5, 32'h1234_5678, 16'd2};
        vec[5] = '{1'b0, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 2'b10, 32'hA5A5_0001, 1, 2, 3, 32'hA5A5_0001, 16'd3};
        vec[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h8, 1, 1, 2, 2'b01, 32'h0, 2, 2, 6, 32'h0, 16'd4};
        post   = '{1'b1, 32'h0000_6000, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1, 1, 3, 32'h0, 16'd0};

        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0; rsp_ready = 1'b0; spurious = 1'b0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_x_dly = 0; cfg_resp = 2'b00; cfg_rdata = 32'h0;
        repeat (3) @(negedge aclk);
        check("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp", {rsp_rdata[29:0], rsp_write, 1'b0} | 32'(rsp_resp), 32'd0);
        check("rst_payload", awaddr | wdata | araddr | 32'(wstrb), 32'd0);
        check("prot_cache", 32'({awprot, arprot, awcache, arcache}), 32'd0);
`ifdef AXIL_ERRCNT_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif

        for (int i = 0; i < 7; i++) run_vec(vec[i]);

        // Response held off for 10 cycles while a read is offered
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_x_dly = 0; cfg_resp = 2'b00; cfg_rdata = 32'h0BAD_F00D;
        hs0 = rsp_hs_cnt;
        start_cmd(1'b1, 32'h0000_6000, 32'h0000_0001, 4'hF);
        wait_rsp(lat);
        bad = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0200;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 ||
                cmd_ready !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check("hold_released_idle", 32'(cmd_ready), 32'd1);
        check("hold_one_response", 32'(rsp_hs_cnt), 32'(hs0 + 1));
        cmd_cyc = cyc;
        @(negedge aclk);
        cmd_valid = 1'b0;
        check("next_cmd_accepted", 32'({arvalid, cmd_ready}), 32'b10);
        wait_rsp(lat);
        check("next_cmd_latency", 32'(lat), 32'd3);
        check("next_cmd_rdata", rsp_rdata, 32'h0BAD_F00D);
        check("next_cmd_araddr", cap_araddr, 32'h0000_0200);
        consume(hs0 + 1);

        // Stray B/R valids while idle must not be accepted
        spurious = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            if (bready !== 1'b0 || rready !== 1'b0 || rsp_valid !== 1'b0) bad++;
        end
        spurious = 1'b0;
        repeat (2) @(negedge aclk);
        check("stray_b_r_ignored", 32'(bad), 32'd0);

        // Reset while waiting in WADDR
        cfg_aw_dly = 20; cfg_w_dly = 20;
        hs0 = rsp_hs_cnt;
        start_cmd(1'b1, 32'h0000_6100, 32'h0000_00FF, 4'hF);
        @(negedge aclk);
        check("waddr_pending", 32'({awvalid, wvalid}), 32'b11);
        #2 aresetn = 1'b0;
        #1;
        check("reset_valids_drop", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
        check("reset_idle", 32'(cmd_ready), 32'd1);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            if (rsp_valid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        check("reset_no_response", 32'(bad), 32'd0);
        check("reset_no_rsp_hs", 32'(rsp_hs_cnt), 32'(hs0));
        run_vec(post);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4lite_cmd_initiator.md
Name: axi4lite_cmd_initiator

Overview:
- Single-outstanding AXI4-Lite initiator (manager). It converts a simple valid/ready command port into one AXI4-Lite read or write transaction.
- It is the initiator end of the bus that MockAXI4LiteSRAM answers.
- Used by benches and debug logic to preload or peek SRAM images, and to poke MMIO such as tohost, without instantiating the core.

Parameters:
- PROT, 3'b000, constant driven on awprot/arprot
- CACHE, 4'b0000, constant driven on awcache/arcache

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  AXI resp code captured from B or R
- awvalid/awready/awaddr[32]/awprot[3]/awcache[4]  AXI4-Lite AW channel, initiator side
- wvalid/wready/wdata[32]/wstrb[4]  AXI4-Lite W channel
- bvalid/bready/bresp[2]  AXI4-Lite B channel
- arvalid/arready/araddr[32]/arprot[3]/arcache[4]  AXI4-Lite AR channel
- rvalid/rready/rdata[32]/rresp[2]  AXI4-Lite R channel
- err_count  out  16  present only with AXIL_ERRCNT_EN

Behaviour:
- Reset (aresetn low, asynchronous) clears every registered output to 0: awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, awaddr, wdata, wstrb, araddr. The FSM returns to IDLE.
  - Reset mid-transaction abandons the transaction; valids drop immediately.
  - No response is produced for the abandoned transaction.
- cmd_ready = (state==IDLE); combinational from state only.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE, cmd_valid=1:
  - If cmd_write=1: register addr/data/strb, set awvalid=wvalid=1, go to WADDR.
  - If cmd_write=0: register addr, set arvalid=1, go to RADDR.
  - awprot/arprot=PROT and awcache/arcache=CACHE at all times.
- WADDR:
  - awvalid clears on the cycle after an aw handshake; wvalid clears on the cycle after a w handshake. The two are tracked independently.
  - When both are done (including the same cycle), set bready=1 and go to WRESP.
  - Payload stays stable while valid is high; valid is never withdrawn before its handshake.
- WRESP: on bvalid&&bready, capture bresp, set rsp_write=1, rsp_rdata=0, rsp_valid=1, clear bready, go to RESP.
- RADDR: on arvalid&&arready, clear arvalid, set rready=1, go to RDATA.
- RDATA: on rvalid&&rready, capture rdata/rresp, set rsp_write=0, rsp_valid=1, clear rready, go to RESP.
- RESP:
  - rsp_* are held stable until rsp_valid&&rsp_ready; then clear rsp_valid and go to IDLE.
  - A new command is accepted no earlier than the following cycle.
- Latency with a zero-wait responder:
  - Write: accept at cycle 0, AW/W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3.
  - Read: accept at cycle 0, AR handshake cycle 1, R handshake cycle 2, rsp_valid cycle 3.
- Exactly one transaction is outstanding. bvalid/rvalid arriving outside WRESP/RDATA is not consumed (ready stays low).
- Non-OKAY resp codes are passed through unchanged; the FSM does not retry.

Optional Feature:
- Macro: AXIL_ERRCNT_EN.
- Defined: err_count port exists. Reset value 0. It increments by 1 on each captured bresp/rresp != 2'b00 and saturates at 16'hFFFF.
- Undefined: err_count port and counter are absent; all other behaviour is identical.

Test Plan:
- Write addr 0x6000, data 0x1, strb 0xF, zero-wait responder -> awaddr=0x6000, wdata=0x1 handshake on cycle 1; rsp_valid cycle 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Write with awready held low 3 cycles, wready immediate -> wvalid drops after cycle 1; awvalid held with stable awaddr until cycle 4; bready rises only after both handshakes; exactly one response.
- Read addr 0x0100 where the responder returns 0xDEADBEEF with rvalid delayed 5 cycles -> rready high throughout the wait; rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_write=0.
- Responder returns bresp=2'b10 -> rsp_resp=2'b10. With AXIL_ERRCNT_EN, err_count goes 0->1; two further SLVERR reads give err_count=3.
- rsp_ready held low 10 cycles -> rsp_* stable; cmd_ready=0 and cmd_valid ignored throughout; the next command is accepted the cycle after rsp_ready rises.
- aresetn pulsed low while in WADDR with awvalid=1 -> all valids 0 immediately, state IDLE, cmd_ready=1 after release, no rsp_valid pulse.
